// File: rtl/noc_flit_pkg.sv
// Flit type encoding shared by the NoC router, pool drivers and flee-side merge logic.
// The type field always occupies the two most significant bits of a flit.
package noc_flit_pkg;

    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    localparam int FLIT_TYPE_W = 2;
    localparam int FLIT_DW_MAX = 64;

    // Callers zero-extend their flit to FLIT_DW_MAX and pass the real width.
    function automatic flit_type_e flit_type(input logic [FLIT_DW_MAX-1:0] data, input int dw);
        logic [FLIT_DW_MAX-1:0] shifted;
        shifted = data >> (dw - FLIT_TYPE_W);
        return flit_type_e'(shifted[FLIT_TYPE_W-1:0]);
    endfunction

    function automatic logic is_head(input flit_type_e t);
        return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
    endfunction

    function automatic logic is_last(input flit_type_e t);
        return (t == FLIT_TAIL) || (t == FLIT_SINGLE);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first requester
// strictly after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/flee_merge_arbiter.sv
// Merges NPORT flee-side flit streams into one registered egress stream with a
// wormhole lock: the winning port owns the egress from its head to its tail.
module flee_merge_arbiter
    import noc_flit_pkg::*;
#(
    parameter int DW    = 32,
    parameter int NPORT = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NPORT*DW-1:0] data_i,
    input  logic [NPORT-1:0]    valid_i,
    output logic [NPORT-1:0]    ready_o,
    output logic [DW-1:0]       data_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [NPORT-1:0]    grant_o,
    output logic                proto_err_o
);

    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]       state_q;
    logic [PW-1:0]    rr_ptr_q;
    logic             first_q;
    logic [PW-1:0]    owner_idx;
    logic [DW-1:0]    owner_data;
    flit_type_e       owner_type;
    flit_type_e       port_type [NPORT];
    logic [NPORT-1:0] cand;
    logic [NPORT-1:0] pick;
    logic             bad_idle;
    logic             out_free;
    logic             accept;

    // Only HEAD/SINGLE can win; a stray BODY/TAIL is flagged and simply never
    // becomes a candidate until that port presents a head type.
    always_comb begin
        cand     = '0;
        bad_idle = 1'b0;
        for (int i = 0; i < NPORT; i++) begin
            port_type[i] = flit_type(FLIT_DW_MAX'(data_i[i*DW +: DW]), DW);
            cand[i]      = valid_i[i] && is_head(port_type[i]);
            if (valid_i[i] && !is_head(port_type[i])) begin
                bad_idle = 1'b1;
            end
        end
    end

    rr_pick #(
        .N  (NPORT),
        .PW (PW)
    ) u_pick (
        .req (cand),
        .ptr (rr_ptr_q),
        .gnt (pick)
    );

    always_comb begin
        owner_data = '0;
        owner_idx  = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (grant_o[i]) begin
                owner_data = owner_data | data_i[i*DW +: DW];
                owner_idx  = PW'(i);
            end
        end
    end

    assign owner_type = flit_type(FLIT_DW_MAX'(owner_data), DW);

    // ready_o depends only on registered owner/valid_o and ready_i.
    assign out_free = ~valid_o | ready_i;
    assign ready_o  = (state_q == ST_LOCK) ? (grant_o & {NPORT{out_free}}) : '0;
    assign accept   = |(valid_i & ready_o);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= PW'(NPORT - 1);
            first_q     <= 1'b0;
            grant_o     <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            proto_err_o <= 1'b0;
        end else begin
            if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
            if (state_q == ST_IDLE && bad_idle) begin
                proto_err_o <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (|pick) begin
                        grant_o <= pick;
                        first_q <= 1'b1;
                        state_q <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (accept) begin
                        data_o  <= owner_data;
                        valid_o <= 1'b1;
                        first_q <= 1'b0;
                        // A second head inside a packet is forwarded but flagged.
                        if (owner_type == FLIT_HEAD && !first_q) begin
                            proto_err_o <= 1'b1;
                        end
                        if (is_last(owner_type)) begin
                            rr_ptr_q <= owner_idx;
                            grant_o  <= '0;
                            state_q  <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
